// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: arbitrates one fixed-latency memory between fetch and data access, gates pipe_en.
// Optional stall-cycle counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        data_req,
  input  logic        data_we,
  input  logic        div_busy,
  output logic        mem_cs,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        inst_done,
  output logic        data_done,
  output logic        pipe_en
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       inst_ok, data_ok;
  logic       inst_pend, data_pend, last;

  assign inst_pend = inst_req & ~inst_ok;
  assign data_pend = data_req & ~data_ok;
  assign last      = (state != IDLE) && (cnt == LAST_CNT);

  assign inst_done = last && (state == INST);
  assign data_done = last && (state == DATA);

  assign mem_cs  = (state != IDLE);
  assign mem_sel = (state == DATA);
  assign mem_we  = (state == DATA) & data_we;

  assign pipe_en = (inst_ok | inst_done) & (~data_req | data_ok | data_done) & ~div_busy;

  // Every access returns to IDLE, which guarantees a turnaround cycle and
  // lets data (older instruction) win each fresh arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (data_pend)      state <= DATA;
          else if (inst_pend) state <= INST;
        end
        INST, DATA: begin
          cnt <= cnt + 4'd1;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
    end else begin
      if (pipe_en)        inst_ok <= 1'b0;
      else if (inst_done) inst_ok <= 1'b1;
      if (pipe_en)        data_ok <= 1'b0;
      else if (data_done) data_ok <= 1'b1;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stall_cnt <= '0;
    else if (!pipe_en) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (WAIT_CYCLES=2) with an expected-output scoreboard queue.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0, div_busy = 1'b0;
  logic mem_cs, mem_sel, mem_we, inst_done, data_done, pipe_en;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [5:0] expq[$];
  string      tagq[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .data_req(data_req), .data_we(data_we), .div_busy(div_busy),
    .mem_cs(mem_cs), .mem_sel(mem_sel), .mem_we(mem_we),
    .inst_done(inst_done), .data_done(data_done), .pipe_en(pipe_en)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  wire [5:0] obs = {mem_cs, mem_sel, mem_we, inst_done, data_done, pipe_en};

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_out();
    logic [5:0] e;
    string t;
    e = expq.pop_front();
    t = tagq.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b (cs,sel,we,idone,ddone,pen)", t, obs, e);
    end
  endtask

  task automatic expect_out(input string t, input logic [5:0] e);
    expq.push_back(e);
    tagq.push_back(t);
  endtask

  // One cycle: drive inputs after the edge, sample combinational outputs mid-cycle.
  task automatic step(input string t, input logic ir, input logic dr, input logic we,
                      input logic db, input logic [5:0] e);
    @(posedge clk); #1;
    rst = 1'b0; inst_req = ir; data_req = dr; data_we = we; div_busy = db;
    expect_out(t, e);
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; inst_req = 0; data_req = 0; data_we = 0; div_busy = 0;
    expect_out("reset", 6'b000000);
    #1 check_out();
  endtask

  initial begin
    // Fetch only
    do_reset();
    step("f_c0", 1,0,0,0, 6'b000000);
    step("f_c1", 1,0,0,0, 6'b100000);
    step("f_c2", 1,0,0,0, 6'b100101);
    step("f_c3", 1,0,0,0, 6'b000000);
    step("f_c4", 1,0,0,0, 6'b100000);
    step("f_c5", 1,0,0,0, 6'b100101);
    step("f_c6", 1,0,0,0, 6'b000000);

    // Fetch and data write together: data first, one pipe_en at the end
    do_reset();
    step("fd_c0", 1,1,1,0, 6'b000000);
    step("fd_c1", 1,1,1,0, 6'b111000);
    step("fd_c2", 1,1,1,0, 6'b111010);
    step("fd_c3", 1,1,1,0, 6'b000000);
    step("fd_c4", 1,1,1,0, 6'b100000);
    step("fd_c5", 1,1,1,0, 6'b100101);

    // Divider busy holds the pipeline and suppresses the next fetch
    do_reset();
    step("dv_c0", 1,0,0,1, 6'b000000);
    step("dv_c1", 1,0,0,1, 6'b100000);
    step("dv_c2", 1,0,0,1, 6'b100100);
    step("dv_c3", 1,0,0,1, 6'b000000);
    step("dv_c4", 1,0,0,1, 6'b000000);
    step("dv_c5", 1,0,0,1, 6'b000000);
    step("dv_c6", 1,0,0,1, 6'b000000);
    step("dv_c7", 1,0,0,0, 6'b000001);
    step("dv_c8", 1,0,0,0, 6'b000000);
    step("dv_c9", 1,0,0,0, 6'b100000);

    // Reset during a data access
    do_reset();
    step("rs_c0", 0,1,1,0, 6'b000000);
    step("rs_c1", 0,1,1,0, 6'b111000);
    #1 rst = 1'b1;
    expect_out("rs_async", 6'b000000);
    #1 check_out();
    @(posedge clk); #1;
    expect_out("rs_held", 6'b000000);
    check_out();
    step("rs_idle", 0,1,1,0, 6'b000000);
    step("rs_acc1", 0,1,1,0, 6'b111000);
    step("rs_acc2", 0,1,1,0, 6'b111010);

`ifdef PIPE_STALL_CNT_EN
    do_reset();
    checks++;
    assert (stall_cnt === 32'd0) else begin
      errors++; $error("FAIL stall_rst got=%0d exp=0", stall_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; inst_req = 1'b1;
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
    checks++;
    assert (stall_cnt === 32'd6) else begin
      errors++; $error("FAIL stall_cnt got=%0d exp=6", stall_cnt);
    end
    do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    @(posedge clk); #1;
    checks++;
    assert (stall_cnt === 32'd0) else begin
      errors++; $error("FAIL stall_wrap got=%0d exp=0", stall_cnt);
    end
`endif

    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
